dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Multi-cycle controller sharing one single-port data memory between the pipeline MEM stage and a
//   loader port (program/data preload, debug). Sequences each access as issue -> wait -> respond,
//   stalls the pipeline until its access completes, and uses pipeline-priority arbitration with a
//   starvation limit for the loader. Sits between the MEM stage and the data-memory macro.
// PARAMETERS
//   ADDR_WIDTH    32  address width, all ports
//   DATA_WIDTH    32  data width, all ports
//   MEM_LATENCY   2   cycles from the m_en issue cycle to valid m_rdata; legal range >= 1
//   STARVE_LIMIT  4   consecutive pipeline grants while l_req is waiting before loader is forced; >= 1
// PORTS
//   clk          in   1    clock, all logic on rising edge
//   rst          in   1    synchronous reset, active-high
//   p_mem_read   in   1    pipeline load request (level, held stable while p_stall=1)
//   p_mem_write  in   1    pipeline store request (level); wins if both are asserted
//   p_addr       in   AW   pipeline address (ALU result)
//   p_wdata      in   DW   pipeline store data
//   p_rdata      out  DW   pipeline load data, registered
//   p_stall      out  1    freeze pipeline; combinational
//   l_req        in   1    loader request (level, held with l_we/l_addr/l_wdata until l_done)
//   l_we         in   1    loader write enable
//   l_addr       in   AW   loader address
//   l_wdata      in   DW   loader write data
//   l_gnt        out  1    1-cycle pulse: loader access issued
//   l_done       out  1    1-cycle pulse: loader access complete, l_rdata valid
//   l_rdata      out  DW   loader read data, registered
//   m_en         out  1    memory access strobe, exactly one cycle per access
//   m_we         out  1    memory write enable, qualified by m_en
//   m_addr       out  AW   memory address
//   m_wdata      out  DW   memory write data
//   m_rdata      in   DW   memory read data, valid MEM_LATENCY cycles after the m_en cycle
// BEHAVIOUR
//   Reset: all registered outputs = 0, state=IDLE, starve counter=0. p_stall forced 0 while rst=1.
//   In-flight access abandoned on reset; no RESP, no l_done. A write already strobed may have landed.
//   FSM: IDLE -> ISSUE -> WAIT (MEM_LATENCY cycles) -> RESP -> IDLE. Owner register = PIPE|LOADER.
//   IDLE: p_req = p_mem_read|p_mem_write. Arbitrate; latch owner, we, addr, wdata into m_* regs.
//   ISSUE: m_en=1, m_we=latched we. l_gnt=1 if owner=LOADER. Load wait counter = MEM_LATENCY.
//   WAIT: decrement counter. On the last WAIT cycle, capture m_rdata into p_rdata or l_rdata by owner.
//   Capture on reads only; the other port's rdata and write accesses leave rdata unchanged.
//   RESP: l_done=1 if owner=LOADER. No arbitration in RESP. Next state is always IDLE.
//   m_en and m_we are 0 outside ISSUE. m_addr/m_wdata hold their last values.
//   p_stall = p_req & ~(state==RESP & owner==PIPE). Pipeline advances at the end of RESP.
//   The request seen in the following IDLE is the next instruction's request.
//   Timing: request in IDLE cycle T -> m_en at T+1, capture at T+1+L, RESP at T+2+L.
//   p_stall is high for L+2 cycles. Total cost is L+3 cycles per access.
//   Arbitration in IDLE:
//     only one requester -> that requester.
//     both requesting, starve_cnt < STARVE_LIMIT -> PIPE; starve_cnt++.
//     both requesting, starve_cnt == STARVE_LIMIT -> LOADER.
//     starve_cnt clears on any LOADER grant, or when l_req=0 at an IDLE cycle.
//   Pipeline p_stall stays high while the loader is served.
//   The loader must drop or change l_req on the edge after l_done; a held l_req is a new request.
// TESTING
//   1 rst=1 for 2 cycles with p_mem_read=1 -> p_stall=0, m_en=0, all outputs 0. Cycle after rst: p_stall=1.
//   2 L=2, p_mem_read, p_addr=0x4, m_rdata=0x12345678 at cycle 3 -> m_en=1 only in cycle 1;
//     p_stall=1 in cycles 0-3; p_rdata=0x12345678 and p_stall=0 in cycle 4.
//   3 p_mem_write, addr 0x4, wdata 0x12345678 -> m_en=m_we=1 one cycle, m_addr=0x4,
//     m_wdata=0x12345678; stall 4 cycles; p_rdata unchanged.
//   4 p_mem_read and l_req (read 0x8) both raised in cycle 0 -> pipeline served first (RESP in cycle 4);
//     loader: l_gnt in cycle 6, l_done in cycle 9; p_stall stays high for the next pipeline request meanwhile.
//   5 STARVE_LIMIT=4, continuous pipeline loads with l_req held -> exactly 4 pipeline grants, then loader
//     granted; counter cleared afterwards.
//   6 rst pulsed during WAIT of a loader read -> IDLE next cycle; no l_done; l_rdata=0.
//     A fresh request then completes normally.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundles the pipeline MEM-stage, loader and data-memory signals of dmem_arbiter.
// The arbiter takes the slave view; pipeline, loader and memory model take the master view.
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // pipeline MEM stage
  logic                  p_mem_read;
  logic                  p_mem_write;
  logic [ADDR_WIDTH-1:0] p_addr;
  logic [DATA_WIDTH-1:0] p_wdata;
  logic [DATA_WIDTH-1:0] p_rdata;
  logic                  p_stall;
  // loader port
  logic                  l_req;
  logic                  l_we;
  logic [ADDR_WIDTH-1:0] l_addr;
  logic [DATA_WIDTH-1:0] l_wdata;
  logic                  l_gnt;
  logic                  l_done;
  logic [DATA_WIDTH-1:0] l_rdata;
  // single-port memory macro
  logic                  m_en;
  logic                  m_we;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic [DATA_WIDTH-1:0] m_rdata;

  modport master (
    output p_mem_read, p_mem_write, p_addr, p_wdata,
    output l_req, l_we, l_addr, l_wdata,
    output m_rdata,
    input  p_rdata, p_stall, l_gnt, l_done, l_rdata,
    input  m_en, m_we, m_addr, m_wdata
  );

  modport slave (
    input  p_mem_read, p_mem_write, p_addr, p_wdata,
    input  l_req, l_we, l_addr, l_wdata,
    input  m_rdata,
    output p_rdata, p_stall, l_gnt, l_done, l_rdata,
    output m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the pipeline and a loader; each access costs MEM_LATENCY+3
// cycles (issue, wait, respond). The pipeline stalls until its access responds; the loader is forced in after STARVE_LIMIT lost rounds.
module dmem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  typedef enum logic {OWN_PIPE, OWN_LOADER} owner_t;

  state_t                state_q, state_d;
  owner_t                owner_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] p_rdata_q;
  logic [DATA_WIDTH-1:0] l_rdata_q;
  logic [CW-1:0]         wait_q;
  logic [SW-1:0]         starve_q, starve_d;
  logic                  p_req;
  logic                  grant;
  logic                  grant_loader;
  logic                  last_wait;

  assign p_req     = bus.p_mem_read | bus.p_mem_write;
  assign last_wait = (state_q == S_WAIT) && (wait_q == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant        = 1'b0;
    grant_loader = 1'b0;
    starve_d     = starve_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.l_req && (!p_req || starve_q == SW'(STARVE_LIMIT))) begin
          grant        = 1'b1;
          grant_loader = 1'b1;
        end else if (p_req) begin
          grant = 1'b1;
        end
        // The counter only tracks pipeline wins taken while the loader sat waiting.
        if (!bus.l_req || grant_loader) begin
          starve_d = '0;
        end else if (grant) begin
          starve_d = starve_q + 1'b1;
        end
        if (grant) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (wait_q == CW'(1)) begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q   <= OWN_PIPE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wait_q    <= '0;
      starve_q  <= '0;
      p_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      starve_q <= starve_d;
      if (grant) begin
        owner_q <= grant_loader ? OWN_LOADER : OWN_PIPE;
        we_q    <= grant_loader ? bus.l_we : bus.p_mem_write;
        addr_q  <= grant_loader ? bus.l_addr : bus.p_addr;
        wdata_q <= grant_loader ? bus.l_wdata : bus.p_wdata;
      end
      if (state_q == S_ISSUE) begin
        wait_q <= CW'(MEM_LATENCY);
      end else if (state_q == S_WAIT) begin
        wait_q <= wait_q - 1'b1;
      end
      if (last_wait && !we_q) begin
        if (owner_q == OWN_LOADER) begin
          l_rdata_q <= bus.m_rdata;
        end else begin
          p_rdata_q <= bus.m_rdata;
        end
      end
    end
  end

  assign bus.m_en    = !rst && (state_q == S_ISSUE);
  assign bus.m_we    = !rst && (state_q == S_ISSUE) && we_q;
  assign bus.m_addr  = addr_q;
  assign bus.m_wdata = wdata_q;
  assign bus.l_gnt   = !rst && (state_q == S_ISSUE) && (owner_q == OWN_LOADER);
  assign bus.l_done  = !rst && (state_q == S_RESP) && (owner_q == OWN_LOADER);
  assign bus.l_rdata = l_rdata_q;
  assign bus.p_rdata = p_rdata_q;
  // The pipeline is released only in its own RESP cycle, so it also waits out loader accesses.
  assign bus.p_stall = !rst && p_req && !((state_q == S_RESP) && (owner_q == OWN_PIPE));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected memory accesses and responses with
// their cycle numbers; a negedge monitor pops and compares whenever the DUT presents one.
module tb_dmem_arbiter;
  localparam int L = 2;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  dmem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(L), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct { int cyc; logic we; logic [31:0] addr; logic [31:0] wdata; } mem_exp_t;
  typedef struct { int cyc; logic [31:0] rdata; } rsp_exp_t;

  mem_exp_t    exp_mem[$];
  rsp_exp_t    exp_p[$];
  rsp_exp_t    exp_l[$];
  int          exp_g[$];
  logic [31:0] mem [0:255];
  logic [31:0] rd_pipe [0:L];

  task automatic chk(input bit ok, input string what);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s", what);
  endtask

  task automatic exp_acc(input int c, input logic w, input logic [31:0] a, input logic [31:0] d);
    mem_exp_t e;
    e.cyc = c; e.we = w; e.addr = a; e.wdata = d;
    exp_mem.push_back(e);
  endtask

  task automatic exp_prsp(input int c, input logic [31:0] d);
    rsp_exp_t r;
    r.cyc = c; r.rdata = d;
    exp_p.push_back(r);
  endtask

  task automatic exp_lrsp(input int c, input logic [31:0] d);
    rsp_exp_t r;
    r.cyc = c; r.rdata = d;
    exp_l.push_back(r);
  endtask

  task automatic wait_p_done();
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.p_stall) begin seen = 1'b1; break; end
    end
    if (!seen) chk(1'b0, $sformatf("p_timeout cyc=%0d p_stall=%b required 0 within 100 cycles", cyc, bus.p_stall));
    @(posedge clk); #1;
  endtask

  task automatic wait_l_done();
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.l_done) begin seen = 1'b1; break; end
    end
    if (!seen) chk(1'b0, $sformatf("l_timeout cyc=%0d l_done=0 required 1 within 100 cycles", cyc));
  endtask

  task automatic p_op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd);
    int b;
    b = cyc;
    exp_acc(b + 1, wr, a, d);
    exp_prsp(b + L + 2, exp_rd);
    bus.p_mem_read = rd; bus.p_mem_write = wr; bus.p_addr = a; bus.p_wdata = d;
    wait_p_done();
  endtask

  task automatic l_op(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_rd);
    int b;
    b = cyc;
    exp_acc(b + 1, we, a, d);
    exp_g.push_back(b + 1);
    exp_lrsp(b + L + 2, exp_rd);
    bus.l_req = 1'b1; bus.l_we = we; bus.l_addr = a; bus.l_wdata = d;
    wait_l_done();
    @(posedge clk); #1;
    bus.l_req = 1'b0;
  endtask

  // Memory macro model: read data appears exactly L cycles after the m_en cycle, garbage otherwise.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[1] = 32'h1234_5678;
    mem[2] = 32'h0000_0808;
    mem[8] = 32'h2020_2020;
    mem[9] = 32'h2424_2424;
    for (int i = 0; i < 9; i++) mem[16 + i] = 32'hA000_0000 + 32'(i);
    for (int i = 0; i <= L; i++) rd_pipe[i] = 32'h0;
    bus.m_rdata = 32'h0;
    forever begin
      @(negedge clk);
      for (int i = L; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
      rd_pipe[0] = 32'hBAD0_0000 | 32'(cyc);
      if (bus.m_en) begin
        if (bus.m_we) mem[bus.m_addr[9:2]] = bus.m_wdata;
        else          rd_pipe[0] = mem[bus.m_addr[9:2]];
      end
      bus.m_rdata = rd_pipe[L];
    end
  end

  initial begin : monitor
    mem_exp_t e;
    rsp_exp_t r;
    int       g;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (bus.m_en) begin
          if (exp_mem.size() == 0) begin
            chk(1'b0, $sformatf("m_en_unexpected cyc=%0d addr=%h required no access", cyc, bus.m_addr));
          end else begin
            e = exp_mem.pop_front();
            chk(cyc == e.cyc && bus.m_we == e.we && bus.m_addr == e.addr && (!e.we || bus.m_wdata == e.wdata),
                $sformatf("m_access got cyc=%0d we=%b addr=%h wdata=%h required cyc=%0d we=%b addr=%h wdata=%h",
                          cyc, bus.m_we, bus.m_addr, bus.m_wdata, e.cyc, e.we, e.addr, e.wdata));
          end
        end else if (bus.m_we) begin
          chk(1'b0, $sformatf("m_we_alone cyc=%0d m_we=1 required 0 without m_en", cyc));
        end
        if ((bus.p_mem_read || bus.p_mem_write) && !bus.p_stall) begin
          if (exp_p.size() == 0) begin
            chk(1'b0, $sformatf("p_release_unexpected cyc=%0d p_stall=0 required 1", cyc));
          end else begin
            r = exp_p.pop_front();
            chk(cyc == r.cyc && bus.p_rdata == r.rdata,
                $sformatf("p_resp got cyc=%0d p_rdata=%h required cyc=%0d p_rdata=%h", cyc, bus.p_rdata, r.cyc, r.rdata));
          end
        end
        if (bus.l_gnt) begin
          if (exp_g.size() == 0) begin
            chk(1'b0, $sformatf("l_gnt_unexpected cyc=%0d l_gnt=1 required 0", cyc));
          end else begin
            g = exp_g.pop_front();
            chk(cyc == g, $sformatf("l_gnt got cyc=%0d required cyc=%0d", cyc, g));
          end
        end
        if (bus.l_done) begin
          if (exp_l.size() == 0) begin
            chk(1'b0, $sformatf("l_done_unexpected cyc=%0d l_done=1 required 0", cyc));
          end else begin
            r = exp_l.pop_front();
            chk(cyc == r.cyc && bus.l_rdata == r.rdata,
                $sformatf("l_done got cyc=%0d l_rdata=%h required cyc=%0d l_rdata=%h", cyc, bus.l_rdata, r.cyc, r.rdata));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required completion before 200000ns", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int b;
    int pg[9];
    rst = 1'b1;
    bus.p_mem_read = 1'b1; bus.p_mem_write = 1'b0; bus.p_addr = 32'h4; bus.p_wdata = 32'h0;
    bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_addr = 32'h0; bus.l_wdata = 32'h0;

    // Reset held with a pending pipeline load: nothing may leak out.
    @(posedge clk);
    @(negedge clk);
    chk(bus.p_stall == 1'b0, $sformatf("reset_p_stall got %b required 0", bus.p_stall));
    chk(!bus.m_en && !bus.m_we && !bus.l_gnt && !bus.l_done,
        $sformatf("reset_strobes got m_en=%b m_we=%b l_gnt=%b l_done=%b required all 0", bus.m_en, bus.m_we, bus.l_gnt, bus.l_done));
    chk(bus.p_rdata == 32'h0 && bus.l_rdata == 32'h0,
        $sformatf("reset_rdata got p=%h l=%h required 0", bus.p_rdata, bus.l_rdata));
    chk(bus.m_addr == 32'h0 && bus.m_wdata == 32'h0,
        $sformatf("reset_maddr got addr=%h wdata=%h required 0", bus.m_addr, bus.m_wdata));
    @(posedge clk); #1;
    rst = 1'b0;
    b = cyc;
    exp_acc(b + 1, 1'b0, 32'h4, 32'h0);
    exp_prsp(b + 4, 32'h1234_5678);
    @(negedge clk);
    chk(bus.p_stall == 1'b1, $sformatf("stall_after_reset got %b required 1", bus.p_stall));
    wait_p_done();

    // Pipeline stores leave p_rdata alone; read-back proves the store landed.
    p_op(1'b0, 1'b1, 32'h4,  32'h1234_5678, 32'h1234_5678);
    p_op(1'b0, 1'b1, 32'h10, 32'hCAFE_F00D, 32'h1234_5678);
    p_op(1'b1, 1'b0, 32'h10, 32'h0,         32'hCAFE_F00D);
    p_op(1'b1, 1'b1, 32'h14, 32'h1111_2222, 32'hCAFE_F00D);
    p_op(1'b1, 1'b0, 32'h14, 32'h0,         32'h1111_2222);
    bus.p_mem_read = 1'b0; bus.p_mem_write = 1'b0;

    // Simultaneous pipeline and loader: pipeline first, loader next, new pipeline load waits.
    b = cyc;
    exp_acc(b + 1,  1'b0, 32'h20, 32'h0);
    exp_acc(b + 6,  1'b0, 32'h8,  32'h0);
    exp_acc(b + 11, 1'b0, 32'h24, 32'h0);
    exp_prsp(b + 4,  32'h2020_2020);
    exp_prsp(b + 14, 32'h2424_2424);
    exp_g.push_back(b + 6);
    exp_lrsp(b + 9, 32'h0000_0808);
    fork
      begin
        bus.p_mem_read = 1'b1; bus.p_addr = 32'h20;
        wait_p_done();
        bus.p_mem_read = 1'b0;
        @(posedge clk); #1;
        bus.p_mem_read = 1'b1; bus.p_addr = 32'h24;
        wait_p_done();
        bus.p_mem_read = 1'b0;
      end
      begin
        bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 32'h8;
        wait_l_done();
        @(posedge clk); #1;
        bus.l_req = 1'b0;
      end
    join

    // Back-to-back pipeline loads with l_req held through two loader accesses.
    b = cyc;
    pg = '{0, 5, 10, 15, 25, 30, 35, 40, 50};
    for (int i = 0; i < 9; i++) begin
      if (i == 4) exp_acc(b + 21, 1'b0, 32'h8, 32'h0);
      if (i == 8) exp_acc(b + 46, 1'b0, 32'h8, 32'h0);
      exp_acc(b + pg[i] + 1, 1'b0, 32'h40 + 32'(4 * i), 32'h0);
      exp_prsp(b + pg[i] + 4, 32'hA000_0000 + 32'(i));
    end
    exp_g.push_back(b + 21);
    exp_g.push_back(b + 46);
    exp_lrsp(b + 24, 32'h0000_0808);
    exp_lrsp(b + 49, 32'h0000_0808);
    fork
      begin
        for (int i = 0; i < 9; i++) begin
          bus.p_mem_read = 1'b1; bus.p_addr = 32'h40 + 32'(4 * i);
          wait_p_done();
        end
        bus.p_mem_read = 1'b0;
      end
      begin
        bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 32'h8;
        wait_l_done();
        wait_l_done();
        @(posedge clk); #1;
        bus.l_req = 1'b0;
      end
    join

    // Reset in the middle of a loader read abandons it.
    b = cyc;
    exp_acc(b + 1, 1'b0, 32'h8, 32'h0);
    exp_g.push_back(b + 1);
    bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 32'h8;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; bus.l_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk(bus.l_rdata == 32'h0 && bus.p_rdata == 32'h0,
        $sformatf("midreset_rdata got l=%h p=%h required 0", bus.l_rdata, bus.p_rdata));
    chk(!bus.l_done && !bus.m_en && !bus.l_gnt,
        $sformatf("midreset_strobes got l_done=%b m_en=%b l_gnt=%b required 0", bus.l_done, bus.m_en, bus.l_gnt));
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    l_op(1'b1, 32'h30, 32'h5555_AAAA, 32'h0);
    l_op(1'b0, 32'h30, 32'h0,         32'h5555_AAAA);

    repeat (5) @(negedge clk);
    chk(exp_mem.size() == 0 && exp_p.size() == 0 && exp_l.size() == 0 && exp_g.size() == 0,
        $sformatf("leftover got mem=%0d p=%0d l=%0d g=%0d required 0", exp_mem.size(), exp_p.size(), exp_l.size(), exp_g.size()));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
